// File: rtl/sine_voice_sequencer.sv
// Sample-rate sequencer for a bank of sine_reader voices: on each tick it requests one
// sample per enabled voice in order, sums them and emits one saturated mixed sample.
module sine_voice_sequencer #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned STEP_W     = 20,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           new_sample_tick,
    input  logic [NUM_VOICES*STEP_W-1:0]   voice_step,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    output logic [NUM_VOICES*STEP_W-1:0]   rdr_step,
    output logic [NUM_VOICES-1:0]          rdr_generate_next,
    input  logic [NUM_VOICES-1:0]          rdr_sample_ready,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] rdr_sample,
    output logic signed [SAMPLE_W-1:0]     mix_sample,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout_err
);

    localparam int unsigned ACC_W = SAMPLE_W + 2;
    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

    logic [1:0]                state;
    logic [NUM_VOICES-1:0]     enable_q;
    logic [IDX_W-1:0]          idx;
    logic [TMR_W-1:0]          timer;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sat;
    logic signed [SAMPLE_W-1:0] cur_sample;
    logic                      cur_ready;
    logic                      last_voice;

    assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));
    assign cur_ready  = rdr_sample_ready[idx];
    assign cur_sample = rdr_sample[int'(idx)*SAMPLE_W +: SAMPLE_W];
    assign busy       = (state != ST_IDLE);

    always_comb begin
        acc_sat = acc;
        if (acc > SAT_MAX) begin
            acc_sat = SAT_MAX;
        end else if (acc < SAT_MIN) begin
            acc_sat = SAT_MIN;
        end
    end

    // Request is decoded from state so a reset removes it in the same cycle.
    always_comb begin
        rdr_generate_next = '0;
        if (state == ST_ISSUE && enable_q[idx]) begin
            rdr_generate_next[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            enable_q    <= '0;
            idx         <= '0;
            timer       <= '0;
            acc         <= '0;
            rdr_step    <= '0;
            mix_sample  <= '0;
            mix_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (new_sample_tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (new_sample_tick) begin
                        rdr_step <= voice_step;
                        enable_q <= voice_enable;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (enable_q[idx]) begin
                        timer <= '0;
                        state <= ST_WAIT;
                    end else if (last_voice) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cur_ready || timer == TMR_W'(TIMEOUT)) begin
                        if (cur_ready) begin
                            acc <= acc + {{2{cur_sample[SAMPLE_W-1]}}, cur_sample};
                        end else begin
                            timeout_err <= 1'b1;
                        end
                        if (last_voice) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    mix_sample <= acc_sat[SAMPLE_W-1:0];
                    mix_valid  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
